// File: rtl/uart_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM UART master port between two byte clients.
// Each grant runs a STATUS poll, then one RX_BASE read or one TX_BASE write.
module uart_port_arbiter (
    input  logic        avm_clk,
    input  logic        avm_rst,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_wr,
    input  logic [15:0] i_wdata,
    output logic [1:0]  o_done,
    output logic [7:0]  o_rdata
);

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;
    localparam int         TX_OK_BIT   = 6;
    localparam int         RX_OK_BIT   = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POLL = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic        grant_r;
    logic        last_r;
    logic        wr_r;
    logic [7:0]  byte_r;
    logic        grant_s;
    logic        ok_s;

    // Round-robin pick: on a tie, the requester not served last wins.
    always_comb begin
        grant_s = 1'b0;
        case (i_req)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Status readiness for the latched direction.
    always_comb begin
        if (wr_r) begin
            ok_s = avm_readdata[TX_OK_BIT];
        end else begin
            ok_s = avm_readdata[RX_OK_BIT];
        end
    end

    // Transaction FSM; all bus and client outputs are registered here.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_r       <= S_IDLE;
            grant_r       <= 1'b0;
            last_r        <= 1'b1;
            wr_r          <= 1'b0;
            byte_r        <= 8'h00;
            avm_address   <= STATUS_BASE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'h0000_0000;
            o_done        <= 2'b00;
            o_rdata       <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    o_done <= 2'b00;
                    if (i_req != 2'b00) begin
                        grant_r     <= grant_s;
                        last_r      <= grant_s;
                        wr_r        <= i_wr[grant_s];
                        byte_r      <= grant_s ? i_wdata[15:8] : i_wdata[7:0];
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_BASE;
                        state_r     <= S_POLL;
                    end
                end
                // Keep re-reading STATUS back to back until the needed bit is set.
                S_POLL: begin
                    if (!avm_waitrequest && ok_s) begin
                        if (wr_r) begin
                            avm_read      <= 1'b0;
                            avm_write     <= 1'b1;
                            avm_address   <= TX_BASE;
                            avm_writedata <= {24'h00_0000, byte_r};
                        end else begin
                            avm_read    <= 1'b1;
                            avm_address <= RX_BASE;
                        end
                        state_r <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!avm_waitrequest) begin
                        if (!wr_r) begin
                            o_rdata <= avm_readdata[7:0];
                        end
                        avm_read    <= 1'b0;
                        avm_write   <= 1'b0;
                        avm_address <= STATUS_BASE;
                        o_done      <= grant_r ? 2'b10 : 2'b01;
                        state_r     <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_done  <= 2'b00;
                    state_r <= S_IDLE;
                end
                default: begin
                    avm_read    <= 1'b0;
                    avm_write   <= 1'b0;
                    avm_address <= STATUS_BASE;
                    o_done      <= 2'b00;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter with a small Avalon UART slave model.
module tb_uart_port_arbiter;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [1:0]  i_req;
    logic [1:0]  i_wr;
    logic [15:0] i_wdata;
    logic [1:0]  o_done;
    logic [7:0]  o_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ready_status;
    logic [7:0] rx_data;
    int         clear_until = 0;
    int         poll_cnt = 0;
    int         stall_n = 0;
    int         stall_cnt = 0;
    int         rx_reads = 0;
    int         tx_writes = 0;
    logic [7:0] last_tx = 8'h00;
    logic       unstable = 1'b0;
    logic       both_cmd = 1'b0;
    logic       both_done = 1'b0;
    logic       prev_rst = 1'b1;
    logic       prev_stall = 1'b0;
    logic [38:0] prev_bus = 39'h0;

    uart_port_arbiter dut (
        .avm_clk        (avm_clk),
        .avm_rst        (avm_rst),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .i_req          (i_req),
        .i_wr           (i_wr),
        .i_wdata        (i_wdata),
        .o_done         (o_done),
        .o_rdata        (o_rdata)
    );

    always #5 avm_clk = ~avm_clk;

    // Slave model: status not-ready until clear_until polls have been served.
    always_comb begin
        avm_waitrequest = (avm_read || avm_write) && (stall_cnt < stall_n);
        if (avm_address == 5'd8) begin
            avm_readdata = {24'h00_0000, (poll_cnt < clear_until) ? 8'h00 : ready_status};
        end else begin
            avm_readdata = {24'h00_0000, rx_data};
        end
    end

    // Bus monitor: counts accepted accesses and flags protocol violations.
    always @(posedge avm_clk) begin
        if (avm_rst) begin
            stall_cnt <= 0;
        end else if ((avm_read || avm_write) && avm_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
        if (!avm_rst && avm_read && !avm_waitrequest) begin
            if (avm_address == 5'd8) poll_cnt <= poll_cnt + 1;
            else if (avm_address == 5'd0) rx_reads <= rx_reads + 1;
        end
        if (!avm_rst && avm_write && !avm_waitrequest) begin
            tx_writes <= tx_writes + 1;
            last_tx   <= avm_writedata[7:0];
        end
        if (avm_read && avm_write) both_cmd <= 1'b1;
        if (o_done == 2'b11) both_done <= 1'b1;
        if (!avm_rst && !prev_rst && prev_stall &&
            ({avm_address, avm_read, avm_write, avm_writedata} != prev_bus)) unstable <= 1'b1;
        prev_rst   <= avm_rst;
        prev_stall <= (avm_read || avm_write) && avm_waitrequest;
        prev_bus   <= {avm_address, avm_read, avm_write, avm_writedata};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output logic [1:0] mask,
                             output logic [7:0] rd);
        cyc  = 0;
        mask = 2'b00;
        rd   = 8'h00;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge avm_clk);
            #1;
            cyc = k + 1;
            if (o_done != 2'b00) begin
                mask = o_done;
                rd   = o_rdata;
                break;
            end
        end
    endtask

    initial begin
        int         c;
        int         base;
        logic [1:0] m;
        logic [7:0] r;
        logic       all_high;
        logic       seen;

        i_req = 2'b00; i_wr = 2'b00; i_wdata = 16'h0000;
        ready_status = 8'h80; rx_data = 8'h00;

        repeat (3) step();
        check("rst_addr", {27'd0, avm_address}, 32'd8);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_write", {31'd0, avm_write}, 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_done", {30'd0, o_done}, 32'd0);
        check("rst_rdata", {24'd0, o_rdata}, 32'd0);
        avm_rst = 1'b0;
        step();

        // Single read, zero wait, status ready on first poll
        ready_status = 8'h80; rx_data = 8'h5A; clear_until = poll_cnt;
        i_req = 2'b01; i_wr = 2'b00;
        step();
        check("rd_c1_read", {31'd0, avm_read}, 32'd1);
        check("rd_c1_addr", {27'd0, avm_address}, 32'd8);
        step();
        check("rd_c2_read", {31'd0, avm_read}, 32'd1);
        check("rd_c2_addr", {27'd0, avm_address}, 32'd0);
        step();
        check("rd_c3_done", {30'd0, o_done}, 32'h1);
        check("rd_c3_rdata", {24'd0, o_rdata}, 32'h5A);
        check("rd_c3_read", {31'd0, avm_read}, 32'd0);
        i_req = 2'b00;
        step();
        check("rd_c4_done", {30'd0, o_done}, 32'd0);

        // Single write from requester 1
        base = rx_reads;
        ready_status = 8'h40;
        i_req = 2'b10; i_wr = 2'b10; i_wdata = 16'hC300;
        step();
        check("wr_c1_read", {31'd0, avm_read}, 32'd1);
        check("wr_c1_addr", {27'd0, avm_address}, 32'd8);
        step();
        check("wr_c2_write", {31'd0, avm_write}, 32'd1);
        check("wr_c2_read", {31'd0, avm_read}, 32'd0);
        check("wr_c2_addr", {27'd0, avm_address}, 32'd4);
        check("wr_c2_wdata", avm_writedata, 32'h0000_00C3);
        step();
        check("wr_c3_done", {30'd0, o_done}, 32'h2);
        check("wr_rdata_held", {24'd0, o_rdata}, 32'h5A);
        check("wr_no_rx", rx_reads - base, 32'd0);
        i_req = 2'b00;
        step();

        // Polling: three not-ready status reads before the ready one
        base = poll_cnt;
        clear_until = poll_cnt + 3;
        ready_status = 8'h80; rx_data = 8'h3C;
        i_req = 2'b01; i_wr = 2'b00;
        all_high = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (!avm_read) all_high = 1'b0;
        end
        wait_done(10, c, m, r);
        check("poll_latency", 5 + c, 32'd6);
        check("poll_read_high", {31'd0, all_high}, 32'd1);
        check("poll_count", poll_cnt - base, 32'd4);
        check("poll_mask", {30'd0, m}, 32'h1);
        check("poll_rdata", {24'd0, r}, 32'h3C);
        i_req = 2'b00;
        step();

        // Waitrequest stretching on STATUS and TX access
        stall_n = 3;
        ready_status = 8'h40;
        i_req = 2'b10; i_wr = 2'b10; i_wdata = 16'h9600;
        wait_done(30, c, m, r);
        check("wait_latency", c, 32'd9);
        check("wait_mask", {30'd0, m}, 32'h2);
        check("wait_txbyte", {24'd0, last_tx}, 32'h96);
        check("wait_stable", {31'd0, unstable}, 32'd0);
        i_req = 2'b00; stall_n = 0;
        step();

        // Reset while the TX write is stalled in transfer
        base = tx_writes;
        stall_n = 5;
        i_req = 2'b10; i_wr = 2'b10; i_wdata = 16'h7700;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (avm_write) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstx_write_seen", {31'd0, seen}, 32'd1);
        step();
        avm_rst = 1'b1;
        #1;
        check("rstx_write", {31'd0, avm_write}, 32'd0);
        check("rstx_addr", {27'd0, avm_address}, 32'd8);
        check("rstx_done", {30'd0, o_done}, 32'd0);
        step();
        check("rstx_done_hold", {30'd0, o_done}, 32'd0);
        avm_rst = 1'b0; stall_n = 0;
        wait_done(10, c, m, r);
        check("rstx_latency", c, 32'd3);
        check("rstx_mask", {30'd0, m}, 32'h2);
        check("rstx_txbyte", {24'd0, last_tx}, 32'h77);
        check("rstx_one_write", tx_writes - base, 32'd1);
        i_req = 2'b00;
        step();

        // Round robin with both requesting continuously from reset
        avm_rst = 1'b1;
        step();
        avm_rst = 1'b0;
        ready_status = 8'hC0; rx_data = 8'h11;
        i_wr = 2'b10; i_wdata = 16'hAA55; i_req = 2'b11;
        wait_done(10, c, m, r);
        check("rr0_latency", c, 32'd3);
        check("rr0_mask", {30'd0, m}, 32'h1);
        check("rr0_rdata", {24'd0, r}, 32'h11);
        wait_done(10, c, m, r);
        check("rr1_latency", c, 32'd4);
        check("rr1_mask", {30'd0, m}, 32'h2);
        check("rr1_txbyte", {24'd0, last_tx}, 32'hAA);
        wait_done(10, c, m, r);
        check("rr2_latency", c, 32'd4);
        check("rr2_mask", {30'd0, m}, 32'h1);
        wait_done(10, c, m, r);
        check("rr3_latency", c, 32'd4);
        check("rr3_mask", {30'd0, m}, 32'h2);
        i_req = 2'b00;
        step();
        check("rr_single_done", {30'd0, o_done}, 32'd0);
        check("never_both_done", {31'd0, both_done}, 32'd0);
        check("never_rd_and_wr", {31'd0, both_cmd}, 32'd0);
        check("bus_stable", {31'd0, unstable}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
